// File: rtl/calc_session_arbiter.sv
// Locks one of two token sources onto a shared calculator core per expression; grant at N+1 after request, result back at N+1 after core strobe.
// Tokens pass through combinationally under core_ready; stalled sessions are aborted by injecting a clear token after TIMEOUT idle cycles.
module calc_session_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_token,
  output logic [1:0]  req_ready,
  output logic [7:0]  core_token,
  output logic        core_valid,
  input  logic        core_ready,
  input  logic [7:0]  core_result,
  input  logic        core_result_valid,
  output logic [1:0]  resp_valid,
  output logic [7:0]  resp_result,
  output logic        resp_error,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RES, FLUSH} state_t;

  localparam logic [7:0] TOK_EQ  = 8'd2;
  localparam logic [7:0] TOK_CLR = 8'd3;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic       owner, owner_n;
  logic       prio, prio_n;
  logic [7:0] cnt, cnt_n;
  logic       resp_fire;
  logic [7:0] resp_res_n;
  logic       resp_err_n;
  logic [7:0] own_tok;
  logic       own_vld;

  assign own_tok = owner ? req_token[15:8] : req_token[7:0];
  assign own_vld = req_valid[owner];

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    prio_n     = prio;
    cnt_n      = cnt;
    req_ready  = 2'b00;
    core_valid = 1'b0;
    core_token = 8'd0;
    resp_fire  = 1'b0;
    resp_res_n = 8'd0;
    resp_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          owner_n = (&req_valid) ? prio : req_valid[1];
          state_n = GRANT;
          cnt_n   = 8'd0;
        end
      end
      GRANT: begin
        req_ready[owner] = core_ready;
        core_valid       = own_vld;
        core_token       = own_vld ? own_tok : 8'd0;
        if (own_vld && core_ready) begin
          cnt_n = 8'd0;
          if (own_tok == TOK_EQ) begin
            state_n = WAIT_RES;
          end else if (own_tok == TOK_CLR) begin
            state_n = IDLE;
            prio_n  = ~owner;
          end
        end else begin
          cnt_n = cnt + 8'd1;
          if (cnt == TO_LAST) state_n = FLUSH;
        end
      end
      WAIT_RES: begin
        if (core_result_valid) begin
          resp_fire  = 1'b1;
          resp_res_n = core_result;
          state_n    = IDLE;
          prio_n     = ~owner;
        end else begin
          cnt_n = cnt + 8'd1;
          if (cnt == TO_LAST) state_n = FLUSH;
        end
      end
      FLUSH: begin
        // No timeout here: the core must eventually take the clear.
        core_valid = 1'b1;
        core_token = TOK_CLR;
        if (core_ready) begin
          resp_fire  = 1'b1;
          resp_err_n = 1'b1;
          state_n    = IDLE;
          prio_n     = ~owner;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      prio        <= 1'b0;
      cnt         <= 8'd0;
      grant       <= 2'b00;
      busy        <= 1'b0;
      resp_valid  <= 2'b00;
      resp_result <= 8'd0;
      resp_error  <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      prio       <= prio_n;
      cnt        <= cnt_n;
      grant      <= (state_n == IDLE) ? 2'b00 : (owner_n ? 2'b10 : 2'b01);
      busy       <= (state_n != IDLE);
      resp_valid <= resp_fire ? (owner ? 2'b10 : 2'b01) : 2'b00;
      if (resp_fire) begin
        resp_result <= resp_res_n;
        resp_error  <= resp_err_n;
      end
    end
  end

endmodule

// File: tb/tb_calc_session_arbiter.sv
// Directed bench for calc_session_arbiter: one instance at TIMEOUT=16, one at TIMEOUT=4 sharing the same stimulus.
module tb_calc_session_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_token;
  logic        core_ready;
  logic [7:0]  core_result;
  logic        core_result_valid;

  logic [1:0]  req_ready, resp_valid, grant;
  logic [7:0]  core_token, resp_result;
  logic        core_valid, resp_error, busy;

  logic [1:0]  req_ready_t, resp_valid_t, grant_t;
  logic [7:0]  core_token_t, resp_result_t;
  logic        core_valid_t, resp_error_t, busy_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  calc_session_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_token(req_token),
    .req_ready(req_ready), .core_token(core_token), .core_valid(core_valid),
    .core_ready(core_ready), .core_result(core_result),
    .core_result_valid(core_result_valid), .resp_valid(resp_valid),
    .resp_result(resp_result), .resp_error(resp_error), .grant(grant), .busy(busy)
  );

  calc_session_arbiter #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_token(req_token),
    .req_ready(req_ready_t), .core_token(core_token_t), .core_valid(core_valid_t),
    .core_ready(core_ready), .core_result(core_result),
    .core_result_valid(core_result_valid), .resp_valid(resp_valid_t),
    .resp_result(resp_result_t), .resp_error(resp_error_t), .grant(grant_t), .busy(busy_t)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00; req_token = 16'h0; core_ready = 1'b0;
    core_result = 8'h0; core_result_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    tick();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_result", resp_result, 8'd0);
    chk("rst_resp_error", resp_error, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_core_valid", core_valid, 1'b0);
    chk("rst_core_token", core_token, 8'd0);

    // Client 0: 5 + 7 = 12
    req_valid = 2'b01; req_token = 16'h0005; core_ready = 1'b1;
    #1;
    chk("t1_idle_ready", req_ready, 2'b00);
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_tok5", core_token, 8'd5);
    tick();
    req_token = 16'h0000; #1;
    chk("t1_tok0", core_token, 8'd0);
    chk("t1_cv0", core_valid, 1'b1);
    tick();
    req_token = 16'h0007; #1;
    chk("t1_tok7", core_token, 8'd7);
    tick();
    req_token = 16'h0002; #1;
    chk("t1_tok2", core_token, 8'd2);
    tick();
    req_valid = 2'b00; #1;
    chk("t1_wait_ready", req_ready, 2'b00);
    chk("t1_wait_cv", core_valid, 1'b0);
    chk("t1_wait_grant", grant, 2'b01);
    tick();
    core_result_valid = 1'b1; core_result = 8'd12;
    tick();
    core_result_valid = 1'b0;
    chk("t1_resp_valid", resp_valid, 2'b01);
    chk("t1_resp_result", resp_result, 8'd12);
    chk("t1_resp_error", resp_error, 1'b0);
    chk("t1_grant_rel", grant, 2'b00);
    chk("t1_busy_rel", busy, 1'b0);
    tick();
    chk("t1_pulse_once", resp_valid, 2'b00);

    // Contention from reset
    do_reset();
    req_valid = 2'b11; req_token = 16'h0202; core_ready = 1'b1;
    tick();
    chk("t2_grant0", grant, 2'b01);
    chk("t2_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; core_result_valid = 1'b1; core_result = 8'd7; #1;
    chk("t2_wait_grant", grant, 2'b01);
    chk("t2_wait_ready", req_ready, 2'b00);
    tick();
    core_result_valid = 1'b0;
    chk("t2_resp0", resp_valid, 2'b01);
    chk("t2_idle_gap", grant, 2'b00);
    tick();
    chk("t2_grant1", grant, 2'b10);
    chk("t2_ready1", req_ready, 2'b10);
    chk("t2_tok1", core_token, 8'd2);
    req_valid = 2'b11;
    tick();
    core_result_valid = 1'b1; core_result = 8'd9; #1;
    chk("t2_wait1_ready", req_ready, 2'b00);
    tick();
    core_result_valid = 1'b0;
    chk("t2_resp1", resp_valid, 2'b10);
    chk("t2_resp1_result", resp_result, 8'd9);
    tick();
    chk("t2_rr_back0", grant, 2'b01);

    // Timeout on TIMEOUT=4 instance: client 1 sends 9, 1 then stalls
    do_reset();
    req_valid = 2'b10; req_token = 16'h0900; core_ready = 1'b1;
    tick();
    chk("t3_grant", grant_t, 2'b10);
    tick();
    req_token = 16'h0100;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    chk("t3_still_grant", grant_t, 2'b10);
    chk("t3_no_cv", core_valid_t, 1'b0);
    tick();
    core_ready = 1'b0; #1;
    chk("t3_flush_cv", core_valid_t, 1'b1);
    chk("t3_flush_tok", core_token_t, 8'd3);
    chk("t3_flush_ready", req_ready_t, 2'b00);
    chk("t3_flush_busy", busy_t, 1'b1);
    tick();
    chk("t3_flush_hold", core_token_t, 8'd3);
    chk("t3_flush_nopulse", resp_valid_t, 2'b00);
    core_ready = 1'b1;
    tick();
    chk("t3_resp_valid", resp_valid_t, 2'b10);
    chk("t3_resp_error", resp_error_t, 1'b1);
    chk("t3_resp_result", resp_result_t, 8'd0);
    chk("t3_dut16_busy", busy, 1'b1);

    // Clear as first token
    do_reset();
    req_valid = 2'b01; req_token = 16'h0003; core_ready = 1'b1;
    tick();
    chk("t4_cv", core_valid, 1'b1);
    chk("t4_tok", core_token, 8'd3);
    chk("t4_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; #1;
    chk("t4_grant_rel", grant, 2'b00);
    chk("t4_busy_rel", busy, 1'b0);
    chk("t4_no_resp", resp_valid, 2'b00);
    req_valid = 2'b11; req_token = 16'h0505;
    tick();
    chk("t4_no_resp2", resp_valid, 2'b00);
    chk("t4_prio_flip", grant, 2'b10);

    // core_ready low for 3 cycles mid-session
    do_reset();
    req_valid = 2'b01; req_token = 16'h0005; core_ready = 1'b1;
    tick();
    tick();
    req_token = 16'h0006; core_ready = 1'b0; #1;
    chk("t5_stall_a", req_ready, 2'b00);
    chk("t5_tok_a", core_token, 8'd6);
    tick();
    chk("t5_stall_b", req_ready, 2'b00);
    tick();
    chk("t5_stall_c", req_ready, 2'b00);
    chk("t5_tok_c", core_token, 8'd6);
    tick();
    core_ready = 1'b1; #1;
    chk("t5_ready_back", req_ready, 2'b01);
    chk("t5_tok_kept", core_token, 8'd6);
    tick();
    req_token = 16'h0002;
    tick();
    req_valid = 2'b00; core_result_valid = 1'b1; core_result = 8'd11;
    tick();
    core_result_valid = 1'b0;
    chk("t5_resp_valid", resp_valid, 2'b01);
    chk("t5_resp_result", resp_result, 8'd11);
    chk("t5_resp_error", resp_error, 1'b0);

    // Reset while in WAIT_RES
    req_valid = 2'b01; req_token = 16'h0002;
    tick();
    tick();
    req_valid = 2'b00; #1;
    chk("t6_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; core_result_valid = 1'b1; core_result = 8'h55; #1;
    chk("t6_grant", grant, 2'b00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_resp_valid", resp_valid, 2'b00);
    chk("t6_resp_result", resp_result, 8'd0);
    chk("t6_resp_error", resp_error, 1'b0);
    chk("t6_req_ready", req_ready, 2'b00);
    chk("t6_core_valid", core_valid, 1'b0);
    chk("t6_core_token", core_token, 8'd0);
    tick();
    core_result_valid = 1'b0;
    chk("t6_late_ignored", resp_valid, 2'b00);
    chk("t6_late_result", resp_result, 8'd0);
    req_valid = 2'b11; req_token = 16'h0404;
    tick();
    chk("t6_prio_reset", grant, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
